// File: rtl/intr_sequencer_if.sv
// Control-path bus between the 6502C control FSM and the interrupt sequencer.
// The master drives pins and FSM strobes, and the slave returns the arbitration results.
interface intr_sequencer_if;
    logic        nmi_n;
    logic        irq_n;
    logic        rdy;
    logic        sync;
    logic [7:0]  opcode_in;
    logic        i_flag;
    logic        vec_fetch;
    logic        seq_done;

    logic        force_brk;
    logic [1:0]  int_type;
    logic [15:0] vector;
    logic        b_push;
    logic        set_i;
    logic        busy;

    modport master (
        output nmi_n, irq_n, rdy, sync, opcode_in, i_flag, vec_fetch, seq_done,
        input  force_brk, int_type, vector, b_push, set_i, busy
    );

    modport slave (
        input  nmi_n, irq_n, rdy, sync, opcode_in, i_flag, vec_fetch, seq_done,
        output force_brk, int_type, vector, b_push, set_i, busy
    );
endinterface

// File: rtl/intr_sequencer.sv
// 6502C interrupt arbiter/sequencer: synchronises NMI/IRQ, forces BRK at opcode
// boundaries and tracks the BRK sequence through vector fetch.
module intr_sequencer (
    input  logic             clk,
    input  logic             rst,
    intr_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RSTSEQ  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        INT_BRK = 2'd0,
        INT_IRQ = 2'd1,
        INT_NMI = 2'd2,
        INT_RST = 2'd3
    } int_e;

    function automatic logic [15:0] vector_of(input int_e t);
        case (t)
            INT_NMI: vector_of = 16'hFFFA;
            INT_RST: vector_of = 16'hFFFC;
            default: vector_of = 16'hFFFE;
        endcase
    endfunction

    state_e      state_q, state_d;
    int_e        type_q, type_d;
    logic [15:0] vector_q, vector_d;
    logic        bflag_q, bflag_d;
    logic        vec_done_q, vec_done_d;

    logic        nmi_s1_q, nmi_s2_q, nmi_s3_q;
    logic        nmi_pend_q, nmi_pend_d;
    logic        irq_s1_q, irq_s2_q;

    logic        nmi_edge;
    logic        nmi_clr;
    logic        irq_req;
    logic        force_brk;
    logic        set_i;

    // The NMI synchroniser and edge latch keep running while rdy is low,
    // so an edge during a stall is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_s1_q   <= 1'b1;
            nmi_s2_q   <= 1'b1;
            nmi_s3_q   <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value of its neighbour, which is what makes this a shift chain.
            nmi_s1_q   <= bus.nmi_n;
            nmi_s2_q   <= nmi_s1_q;
            nmi_s3_q   <= nmi_s2_q;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign nmi_edge   = nmi_s3_q & ~nmi_s2_q;
    assign nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_s1_q <= 1'b1;
            irq_s2_q <= 1'b1;
        end else if (bus.rdy) begin
            irq_s1_q <= bus.irq_n;
            irq_s2_q <= irq_s1_q;
        end
    end

    assign irq_req = ~irq_s2_q & ~bus.i_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RSTSEQ;
            type_q     <= INT_RST;
            vector_q   <= 16'hFFFC;
            bflag_q    <= 1'b0;
            vec_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            vector_q   <= vector_d;
            bflag_q    <= bflag_d;
            vec_done_q <= vec_done_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        type_d     = type_q;
        vector_d   = vector_q;
        bflag_d    = bflag_q;
        vec_done_d = vec_done_q;
        force_brk  = 1'b0;
        set_i      = 1'b0;
        nmi_clr    = 1'b0;

        case (state_q)
            ST_RSTSEQ: begin
                if (bus.rdy) begin
                    set_i = bus.vec_fetch;
                    if (bus.seq_done) state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (bus.sync && bus.rdy) begin
                    if (nmi_pend_q) begin
                        force_brk  = 1'b1;
                        type_d     = INT_NMI;
                        bflag_d    = 1'b0;
                        vec_done_d = 1'b0;
                        state_d    = ST_SERVICE;
                    end else if (irq_req) begin
                        force_brk  = 1'b1;
                        type_d     = INT_IRQ;
                        bflag_d    = 1'b0;
                        vec_done_d = 1'b0;
                        state_d    = ST_SERVICE;
                    end else if (bus.opcode_in == 8'h00) begin
                        type_d     = INT_BRK;
                        bflag_d    = 1'b1;
                        vec_done_d = 1'b0;
                        state_d    = ST_SERVICE;
                    end
                    vector_d = vector_of(type_d);
                end
            end

            ST_SERVICE: begin
                if (bus.rdy) begin
                    // Only the first vec_fetch of a sequence commits the vector;
                    // a pending NMI at that moment hijacks an IRQ or BRK.
                    if (bus.vec_fetch && !vec_done_q) begin
                        vec_done_d = 1'b1;
                        set_i      = 1'b1;
                        if (type_q == INT_NMI) begin
                            nmi_clr = 1'b1;
                        end else if (nmi_pend_q) begin
                            type_d   = INT_NMI;
                            vector_d = vector_of(INT_NMI);
                            nmi_clr  = 1'b1;
                        end
                    end
                    if (bus.seq_done) state_d = ST_IDLE;
                end
            end

            default: state_d = ST_RSTSEQ;
        endcase
    end

    assign bus.force_brk = force_brk;
    assign bus.set_i     = set_i;
    assign bus.int_type  = type_q;
    assign bus.vector    = vector_q;
    assign bus.b_push    = (state_q == ST_SERVICE) & bflag_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_intr_sequencer.sv
// Directed testbench for intr_sequencer: one task per scenario with inline
// comparisons against hand-computed values.
module tb_intr_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    intr_sequencer_if bus ();

    intr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance n cycles; inputs are changed and outputs sampled 2 time units after posedge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_vec_fetch();
        bus.vec_fetch = 1'b1;
        cyc(1);
        bus.vec_fetch = 1'b0;
    endtask

    task automatic pulse_seq_done();
        bus.seq_done = 1'b1;
        cyc(1);
        bus.seq_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        #1;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        n_tests++; if (bus.int_type !== 2'd3) begin n_fail++; $display("FAIL reset_type: got %0d want 3", bus.int_type); end
        n_tests++; if (bus.vector !== 16'hFFFC) begin n_fail++; $display("FAIL reset_vector: got %h want fffc", bus.vector); end
        n_tests++; if (bus.b_push !== 1'b0 || bus.set_i !== 1'b0 || bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got b_push=%b set_i=%b force=%b want 0 0 0", bus.b_push, bus.set_i, bus.force_brk); end
        // RSTSEQ must ignore a sync with a BRK opcode on the bus.
        bus.sync = 1'b1; bus.opcode_in = 8'h00;
        #1;
        n_tests++; if (bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL rstseq_no_force: got %b want 0", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0; bus.opcode_in = 8'hEA;
        cyc(3);
        n_tests++; if (bus.busy !== 1'b1 || bus.int_type !== 2'd3) begin n_fail++; $display("FAIL rstseq_hold: got busy=%b type=%0d want 1 3", bus.busy, bus.int_type); end
        pulse_seq_done();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_to_idle: got busy=%b want 0", bus.busy); end
        n_tests++; if (bus.b_push !== 1'b0) begin n_fail++; $display("FAIL idle_b_push: got %b want 0", bus.b_push); end
    endtask

    task automatic test_nmi_edge();
        bus.nmi_n = 1'b0;
        cyc(4);
        bus.sync = 1'b1; bus.opcode_in = 8'hA9;
        #1;
        n_tests++; if (bus.force_brk !== 1'b1) begin n_fail++; $display("FAIL nmi_force: got %b want 1", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0;
        n_tests++; if (bus.busy !== 1'b1 || bus.int_type !== 2'd2) begin n_fail++; $display("FAIL nmi_type: got busy=%b type=%0d want 1 2", bus.busy, bus.int_type); end
        n_tests++; if (bus.vector !== 16'hFFFA) begin n_fail++; $display("FAIL nmi_vector: got %h want fffa", bus.vector); end
        n_tests++; if (bus.b_push !== 1'b0) begin n_fail++; $display("FAIL nmi_b_push: got %b want 0", bus.b_push); end
        cyc(1);
        bus.vec_fetch = 1'b1;
        #1;
        n_tests++; if (bus.set_i !== 1'b1) begin n_fail++; $display("FAIL nmi_set_i: got %b want 1", bus.set_i); end
        cyc(1);
        bus.vec_fetch = 1'b0;
        #1;
        n_tests++; if (bus.set_i !== 1'b0) begin n_fail++; $display("FAIL nmi_set_i_pulse: got %b want 0", bus.set_i); end
        cyc(1);
        pulse_seq_done();
        n_tests++; if (bus.busy !== 1'b0 || bus.int_type !== 2'd2) begin n_fail++; $display("FAIL nmi_done: got busy=%b type=%0d want 0 2", bus.busy, bus.int_type); end
        // nmi_n still low: no new edge, and nmi_pend was cleared by vec_fetch.
        cyc(3);
        bus.sync = 1'b1; bus.opcode_in = 8'hA9;
        #1;
        n_tests++; if (bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL nmi_no_retrigger: got %b want 0", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL nmi_stay_idle: got busy=%b want 0", bus.busy); end
        bus.nmi_n = 1'b1;
        cyc(4);
    endtask

    task automatic test_irq_mask();
        bus.irq_n = 1'b0; bus.i_flag = 1'b1;
        cyc(4);
        bus.sync = 1'b1; bus.opcode_in = 8'hA9;
        #1;
        n_tests++; if (bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL irq_masked_idle: got busy=%b want 0", bus.busy); end
        cyc(1);
        bus.i_flag = 1'b0; bus.sync = 1'b1;
        #1;
        n_tests++; if (bus.force_brk !== 1'b1) begin n_fail++; $display("FAIL irq_force: got %b want 1", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0;
        n_tests++; if (bus.int_type !== 2'd1 || bus.vector !== 16'hFFFE) begin n_fail++; $display("FAIL irq_type_vec: got type=%0d vec=%h want 1 fffe", bus.int_type, bus.vector); end
        n_tests++; if (bus.b_push !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL irq_bpush_busy: got b_push=%b busy=%b want 0 1", bus.b_push, bus.busy); end
        bus.irq_n = 1'b1;
        cyc(1);
        pulse_vec_fetch();
        bus.i_flag = 1'b1;
        pulse_seq_done();
        n_tests++; if (bus.busy !== 1'b0 || bus.int_type !== 2'd1) begin n_fail++; $display("FAIL irq_done: got busy=%b type=%0d want 0 1", bus.busy, bus.int_type); end
        bus.i_flag = 1'b0;
        cyc(3);
    endtask

    task automatic test_sw_brk();
        bus.sync = 1'b1; bus.opcode_in = 8'h00;
        #1;
        n_tests++; if (bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL brk_no_force: got %b want 0", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0; bus.opcode_in = 8'hEA;
        n_tests++; if (bus.int_type !== 2'd0 || bus.b_push !== 1'b1) begin n_fail++; $display("FAIL brk_type_bpush: got type=%0d b_push=%b want 0 1", bus.int_type, bus.b_push); end
        n_tests++; if (bus.vector !== 16'hFFFE || bus.busy !== 1'b1) begin n_fail++; $display("FAIL brk_vec_busy: got vec=%h busy=%b want fffe 1", bus.vector, bus.busy); end
        // A sync during SERVICE is ignored.
        bus.sync = 1'b1; bus.opcode_in = 8'h00;
        #1;
        n_tests++; if (bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL brk_service_sync: got %b want 0", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0; bus.opcode_in = 8'hEA;
        bus.vec_fetch = 1'b1;
        #1;
        n_tests++; if (bus.set_i !== 1'b1) begin n_fail++; $display("FAIL brk_set_i: got %b want 1", bus.set_i); end
        cyc(1);
        bus.vec_fetch = 1'b0;
        pulse_seq_done();
        n_tests++; if (bus.busy !== 1'b0 || bus.b_push !== 1'b0) begin n_fail++; $display("FAIL brk_done: got busy=%b b_push=%b want 0 0", bus.busy, bus.b_push); end
        // vec_fetch in IDLE is ignored.
        bus.vec_fetch = 1'b1;
        #1;
        n_tests++; if (bus.set_i !== 1'b0) begin n_fail++; $display("FAIL idle_vec_fetch: got set_i=%b want 0", bus.set_i); end
        cyc(1);
        bus.vec_fetch = 1'b0;
        cyc(1);
    endtask

    task automatic test_nmi_hijack();
        bus.sync = 1'b1; bus.opcode_in = 8'h00;
        cyc(1);
        bus.sync = 1'b0; bus.opcode_in = 8'hEA;
        bus.nmi_n = 1'b0;
        cyc(4);
        n_tests++; if (bus.int_type !== 2'd0 || bus.vector !== 16'hFFFE) begin n_fail++; $display("FAIL hijack_pre: got type=%0d vec=%h want 0 fffe", bus.int_type, bus.vector); end
        bus.vec_fetch = 1'b1;
        #1;
        n_tests++; if (bus.set_i !== 1'b1) begin n_fail++; $display("FAIL hijack_set_i: got %b want 1", bus.set_i); end
        cyc(1);
        bus.vec_fetch = 1'b0;
        n_tests++; if (bus.int_type !== 2'd2 || bus.vector !== 16'hFFFA) begin n_fail++; $display("FAIL hijack_vec: got type=%0d vec=%h want 2 fffa", bus.int_type, bus.vector); end
        n_tests++; if (bus.b_push !== 1'b1) begin n_fail++; $display("FAIL hijack_bpush: got %b want 1", bus.b_push); end
        pulse_seq_done();
        bus.nmi_n = 1'b1;
        cyc(3);
        bus.sync = 1'b1; bus.opcode_in = 8'hA9;
        #1;
        n_tests++; if (bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL hijack_pend_clear: got force=%b want 0", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0;
        cyc(1);
    endtask

    task automatic test_priority_stall();
        bus.nmi_n = 1'b0; bus.irq_n = 1'b0; bus.i_flag = 1'b0;
        cyc(5);
        bus.rdy = 1'b0; bus.sync = 1'b1; bus.opcode_in = 8'hA9;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL stall_force_%0d: got %b want 0", i, bus.force_brk); end
            cyc(1);
            n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle_%0d: got busy=%b want 0", i, bus.busy); end
        end
        bus.rdy = 1'b1;
        #1;
        n_tests++; if (bus.force_brk !== 1'b1) begin n_fail++; $display("FAIL prio_force: got %b want 1", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0;
        n_tests++; if (bus.int_type !== 2'd2 || bus.vector !== 16'hFFFA) begin n_fail++; $display("FAIL prio_nmi_first: got type=%0d vec=%h want 2 fffa", bus.int_type, bus.vector); end
        pulse_vec_fetch();
        pulse_seq_done();
        bus.sync = 1'b1;
        #1;
        n_tests++; if (bus.force_brk !== 1'b1) begin n_fail++; $display("FAIL prio_irq_force: got %b want 1", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0;
        n_tests++; if (bus.int_type !== 2'd1 || bus.vector !== 16'hFFFE) begin n_fail++; $display("FAIL prio_irq_next: got type=%0d vec=%h want 1 fffe", bus.int_type, bus.vector); end
        bus.irq_n = 1'b1; bus.nmi_n = 1'b1;
        pulse_vec_fetch();
        bus.i_flag = 1'b1;
        pulse_seq_done();
        cyc(4);
    endtask

    task automatic test_reset_midop();
        bus.sync = 1'b1; bus.opcode_in = 8'h00;
        cyc(1);
        bus.sync = 1'b0; bus.opcode_in = 8'hEA;
        bus.nmi_n = 1'b0;
        cyc(4);
        n_tests++; if (bus.busy !== 1'b1 || bus.int_type !== 2'd0) begin n_fail++; $display("FAIL midop_service: got busy=%b type=%0d want 1 0", bus.busy, bus.int_type); end
        rst = 1'b1; bus.nmi_n = 1'b1;
        cyc(1);
        rst = 1'b0;
        n_tests++; if (bus.int_type !== 2'd3 || bus.vector !== 16'hFFFC) begin n_fail++; $display("FAIL midop_rstseq: got type=%0d vec=%h want 3 fffc", bus.int_type, bus.vector); end
        n_tests++; if (bus.busy !== 1'b1 || bus.b_push !== 1'b0) begin n_fail++; $display("FAIL midop_busy: got busy=%b b_push=%b want 1 0", bus.busy, bus.b_push); end
        cyc(3);
        pulse_seq_done();
        bus.sync = 1'b1; bus.opcode_in = 8'hA9;
        #1;
        n_tests++; if (bus.force_brk !== 1'b0) begin n_fail++; $display("FAIL midop_pend_clear: got force=%b want 0", bus.force_brk); end
        cyc(1);
        bus.sync = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midop_idle: got busy=%b want 0", bus.busy); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.nmi_n     = 1'b1;
        bus.irq_n     = 1'b1;
        bus.rdy       = 1'b1;
        bus.sync      = 1'b0;
        bus.opcode_in = 8'hEA;
        bus.i_flag    = 1'b1;
        bus.vec_fetch = 1'b0;
        bus.seq_done  = 1'b0;

        test_reset();
        test_nmi_edge();
        test_irq_mask();
        test_sw_brk();
        test_nmi_hijack();
        test_priority_stall();
        test_reset_midop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
